// File: rtl/pwm_compare.sv
// Compare-based PWM generator with shadowed period/duty, IDLE/START/RUN sequencing
// and optional dead-time insertion (enabled by defining PWM_DEADTIME_EN).
module pwm_compare #(
  parameter int W    = 16,
  parameter int DT_W = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            enable,
  input  logic [W-1:0]    CNT,
  input  logic [W-1:0]    PER_IN,
  input  logic [W-1:0]    DUTY_IN,
  input  logic            wr,
  input  logic [DT_W-1:0] DT,
  output logic [W-1:0]    COMP0,
  output logic            load,
  output logic            period_done,
  output logic            PWM_H,
  output logic            PWM_L
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_RUN   = 2'd2
  } state_t;

  state_t         r_state;
  state_t         w_state_next;
  logic [W-1:0]   r_per_sh;
  logic [W-1:0]   r_duty_sh;
  logic [W-1:0]   r_per_act;
  logic [W-1:0]   r_duty_act;
  logic           r_pending;
  logic           r_load;
  logic           r_period_done;
  logic           r_pwm_h;
  logic           r_pwm_l;
  logic           w_run_en;
  logic           w_bnd;
  logic           w_xfer;
  logic           w_pending_next;
  logic           w_raw;
  logic           w_pwm_h_next;
  logic           w_pwm_l_next;

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (enable) w_state_next = S_START;
        else        w_state_next = S_IDLE;
      end
      S_START: w_state_next = S_RUN;
      S_RUN: begin
        if (enable) w_state_next = S_RUN;
        else        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Period boundary, shadow transfer and raw compare decode
  always_comb begin
    w_run_en = (r_state == S_RUN) && enable;
    w_bnd    = w_run_en && (CNT == {W{1'b0}});
    // Outside RUN the active set tracks the shadow continuously
    w_xfer   = (r_state != S_RUN) || (w_bnd && r_pending);
    w_raw    = w_run_en && (CNT < r_duty_act);
    if (wr) begin
      w_pending_next = 1'b1;
    end else if ((r_state != S_RUN) || w_bnd) begin
      w_pending_next = 1'b0;
    end else begin
      w_pending_next = r_pending;
    end
  end

`ifdef PWM_DEADTIME_EN
  localparam logic [DT_W-1:0] DT_ZERO = {DT_W{1'b0}};
  localparam logic [DT_W-1:0] DT_ONE  = {{(DT_W-1){1'b0}}, 1'b1};

  logic            r_raw;
  logic [DT_W-1:0] r_dt_cnt;
  logic [DT_W-1:0] w_dt_next;

  // Dead-time counter restarts on every raw edge; a side may turn on only at zero
  always_comb begin
    if (w_raw != r_raw) begin
      w_dt_next = DT;
    end else if (r_dt_cnt != DT_ZERO) begin
      w_dt_next = r_dt_cnt - DT_ONE;
    end else begin
      w_dt_next = r_dt_cnt;
    end
    w_pwm_h_next = w_raw && (w_dt_next == DT_ZERO);
    w_pwm_l_next = w_run_en && !w_raw && (w_dt_next == DT_ZERO);
  end

  // Dead-time tracking state
  always_ff @(posedge clk) begin
    if (reset) begin
      r_raw    <= 1'b0;
      r_dt_cnt <= DT_ZERO;
    end else begin
      r_raw    <= w_raw;
      r_dt_cnt <= w_dt_next;
    end
  end
`else
  logic w_unused_dt;

  // Complementary drive without dead-time
  always_comb begin
    w_unused_dt  = ^DT;
    w_pwm_h_next = w_raw;
    w_pwm_l_next = w_run_en && !w_raw;
  end
`endif

  // State, shadow/active registers and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_per_sh      <= {W{1'b0}};
      r_duty_sh     <= {W{1'b0}};
      r_per_act     <= {W{1'b0}};
      r_duty_act    <= {W{1'b0}};
      r_pending     <= 1'b0;
      r_load        <= 1'b0;
      r_period_done <= 1'b0;
      r_pwm_h       <= 1'b0;
      r_pwm_l       <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (wr) begin
        r_per_sh  <= PER_IN;
        r_duty_sh <= DUTY_IN;
      end
      // Old shadow moves to active even when a write lands on the same edge
      if (w_xfer) begin
        r_per_act  <= r_per_sh;
        r_duty_act <= r_duty_sh;
      end
      r_pending     <= w_pending_next;
      r_load        <= ((r_state == S_IDLE) && enable) || w_bnd;
      r_period_done <= w_bnd;
      r_pwm_h       <= w_pwm_h_next;
      r_pwm_l       <= w_pwm_l_next;
    end
  end

  assign COMP0       = r_per_act;
  assign load        = r_load;
  assign period_done = r_period_done;
  assign PWM_H       = r_pwm_h;
  assign PWM_L       = r_pwm_l;

endmodule

// File: tb/tb_pwm_compare.sv
// Directed + randomized bench for pwm_compare against a cycle-level behavioural model.
module tb_pwm_compare;
  localparam int W    = 16;
  localparam int DT_W = 8;

  logic            clk = 1'b0;
  logic            reset;
  logic            enable;
  logic            wr;
  logic [W-1:0]    cnt;
  logic [W-1:0]    per_in;
  logic [W-1:0]    duty_in;
  logic [DT_W-1:0] dt;
  logic [W-1:0]    comp0;
  logic            load;
  logic            period_done;
  logic            pwm_h;
  logic            pwm_l;

  always #5 clk = ~clk;

  pwm_compare #(.W(W), .DT_W(DT_W)) dut (
    .clk(clk), .reset(reset), .enable(enable), .CNT(cnt),
    .PER_IN(per_in), .DUTY_IN(duty_in), .wr(wr), .DT(dt),
    .COMP0(comp0), .load(load), .period_done(period_done),
    .PWM_H(pwm_h), .PWM_L(pwm_l)
  );

  // Behavioural model: mode 0 = idle, 1 = start, 2 = run
  int          m_mode = 0;
  logic [W-1:0] m_per_sh = '0, m_duty_sh = '0, m_per_act = '0, m_duty_act = '0;
  bit          m_pend = 0, m_load = 0, m_pd = 0, m_h = 0, m_l = 0;
  bit          hist[$];
  // Upstream down-counter stimulus: started by load, reloads from COMP0 at zero
  logic [W-1:0] c_val = '0;
  bit          c_run = 0;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0b expected %0b at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_vec(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Raw level held for d+1 consecutive samples (missing history counts as low)
  function automatic bit held_for(input bit v, input int unsigned d);
    for (int i = 0; i <= int'(d); i++) begin
      bit s;
      s = (i < hist.size()) ? hist[i] : 1'b0;
      if (s != v) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic step();
    bit           run_en, bnd, raw, held;
    logic [W-1:0] nc;
    bit           ncr;
    run_en = (m_mode == 2) && enable;
    bnd    = run_en && (cnt == 0);
    raw    = run_en && (cnt < m_duty_act);
    // Counter stimulus uses what the DUT showed before this edge
    ncr = c_run;
    nc  = c_val;
    if (reset) begin
      ncr = 0; nc = '0;
    end else if (!c_run && m_load) begin
      ncr = 1; nc = m_per_act;
    end else if (c_run) begin
      nc = (c_val == 0) ? m_per_act : c_val - 1;
    end
    @(posedge clk);
    if (reset) begin
      m_mode = 0; m_per_sh = '0; m_duty_sh = '0; m_per_act = '0; m_duty_act = '0;
      m_pend = 0; m_load = 0; m_pd = 0; m_h = 0; m_l = 0;
      hist.delete();
    end else begin
      m_load = (m_mode == 0 && enable) || bnd;
      m_pd   = bnd;
      if (m_mode != 2 || (bnd && m_pend)) begin
        m_per_act  = m_per_sh;
        m_duty_act = m_duty_sh;
      end
      m_pend = wr ? 1'b1 : ((m_mode != 2 || bnd) ? 1'b0 : m_pend);
      if (wr) begin
        m_per_sh  = per_in;
        m_duty_sh = duty_in;
      end
      case (m_mode)
        0:       m_mode = enable ? 1 : 0;
        1:       m_mode = 2;
        default: m_mode = enable ? 2 : 0;
      endcase
      hist.push_front(raw);
      if (hist.size() > 300) void'(hist.pop_back());
`ifdef PWM_DEADTIME_EN
      held = held_for(raw, dt);
`else
      held = 1'b1;
`endif
      m_h = raw && held;
      m_l = run_en && !raw && held;
    end
    if (m_mode == 0) ncr = 0;
    c_run = ncr;
    c_val = nc;
    #1;
    check_bit("load", load, m_load);
    check_bit("period_done", period_done, m_pd);
    check_bit("pwm_h", pwm_h, m_h);
    check_bit("pwm_l", pwm_l, m_l);
    check_vec("comp0", comp0, m_per_act);
    check_bit("no_overlap", pwm_h & pwm_l, 1'b0);
    cnt = c_val;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic write_sh(input int p, input int d);
    per_in = W'(p); duty_in = W'(d); wr = 1'b1;
    step();
    wr = 1'b0;
  endtask

  task automatic wait_cnt(input int v, input string tag);
    int k;
    k = 0;
    while (cnt != W'(v) && k < 60) begin
      step();
      k++;
    end
    n_cmp++;
    if (k >= 60) begin
      n_fail++;
      $error("FAIL %s: counter never reached %0d within 60 cycles", tag, v);
    end
  endtask

  initial begin
    int n_ld, n_hi;
    reset = 1'b1; enable = 1'b1; wr = 1'b1; cnt = '0;
    per_in = 16'd7; duty_in = 16'd2; dt = 8'd2;
    run(2);
    check_vec("reset_comp0", comp0, 16'd0);
    check_bit("reset_load", load, 1'b0);
    reset = 1'b0; enable = 1'b0; wr = 1'b0;
    run(2);

    // PER=9 DUTY=3: 10-cycle period, 3 raw-high cycles each
    write_sh(9, 3);
    enable = 1'b1;
    run(25);
    n_ld = 0; n_hi = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      n_ld += int'(load);
      n_hi += int'(pwm_h);
    end
    check_vec("win_loads", W'(n_ld), 16'd2);
`ifdef PWM_DEADTIME_EN
    check_vec("win_high_dt", W'(n_hi), 16'd2);
`else
    check_vec("win_high", W'(n_hi), 16'd6);
`endif

    // Mid-period shadow write applies only after the boundary
    wait_cnt(5, "wait_mid1");
    write_sh(4, 2);
    check_vec("comp0_hold", comp0, 16'd9);
    run(30);

    // 0% then 100% duty
    write_sh(9, 0);
    run(30);
    write_sh(9, 12);
    run(25);
    n_hi = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      n_hi += int'(pwm_h);
    end
    check_vec("win_full", W'(n_hi), 16'd20);

    // PER=0 reloads every cycle
    write_sh(0, 1);
    run(15);

    // Stop mid-period, shadow keeps flowing to active
    write_sh(9, 3);
    run(15);
    wait_cnt(5, "wait_mid2");
    enable = 1'b0;
    run(3);
    write_sh(6, 4);
    run(2);
    check_vec("idle_track", comp0, 16'd6);

    // Reset mid-period with enable and wr asserted
    enable = 1'b1;
    run(14);
    reset = 1'b1; wr = 1'b1;
    step();
    reset = 1'b0; wr = 1'b0;
    run(3);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      reset   = ($urandom_range(0, 199) == 0);
      enable  = ($urandom_range(0, 29) != 0);
      wr      = ($urandom_range(0, 11) == 0);
      per_in  = W'($urandom_range(0, 15));
      duty_in = W'($urandom_range(0, 18));
`ifndef PWM_DEADTIME_EN
      dt      = DT_W'($urandom_range(0, 255));
`endif
      if ($urandom_range(0, 15) == 0) cnt = W'($urandom_range(0, 20));
      step();
    end
    wr = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/pwm_compare.md
PWM_COMPARE -- requirements
Module: pwm_compare

Interface
REQ-001 Parameter W, default 16, SHALL set the counter, period and duty width.
REQ-002 Parameter DT_W, default 8, SHALL set the dead-time width.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 reset  input  1  SHALL be a synchronous, active-high reset.
REQ-005 enable  input  1  SHALL be the run request; 1 = generate PWM, 0 = stop.
REQ-006 CNT  input  W  SHALL be the current value of the upstream down-counter.
REQ-007 PER_IN  input  W  SHALL be the period value to write into the shadow register.
REQ-008 DUTY_IN  input  W  SHALL be the duty value to write into the shadow register.
REQ-009 wr  input  1  SHALL be the shadow write strobe.
REQ-010 DT  input  DT_W  SHALL be the dead-time in clk cycles.
REQ-011 COMP0  output  W  SHALL be the active period, fed to the counter reload value.
REQ-012 load  output  1  SHALL be the registered one-cycle counter reload pulse.
REQ-013 period_done  output  1  SHALL be a registered one-cycle pulse at each period boundary.
REQ-014 PWM_H, PWM_L  output  1 each  SHALL be the high-side and low-side gate drives.

Function
REQ-015 If wr=1, the block SHALL capture PER_IN and DUTY_IN into the shadow registers and set the pending flag on the next edge.
REQ-016 The FSM SHALL have three states: IDLE, START and RUN.
REQ-017 IDLE: load=0; PWM_H and PWM_L=0; active registers copy the shadow registers every cycle; pending is cleared.
REQ-018 In IDLE with enable=1, the next state SHALL be START.
REQ-019 START: load=1 for exactly one cycle, the active registers take the shadow, and the next state is RUN.
REQ-020 In RUN with enable=0, the next state SHALL be IDLE and both outputs SHALL be 0 from the following cycle.
REQ-021 In RUN with CNT==0 and enable=1, the block SHALL drive load=1 and period_done=1 for one cycle.
REQ-022 In the case of REQ-021, if pending=1, the active registers SHALL take the shadow and pending SHALL clear.
REQ-023 When wr coincides with a boundary transfer, the old shadow SHALL transfer, the new values SHALL be captured, and pending SHALL remain 1.
REQ-024 The raw PWM signal SHALL be (CNT < DUTY_active), registered, so PWM_H lags CNT by 1 cycle.
REQ-025 DUTY_active=0 SHALL give 0% duty (PWM_H never high).
REQ-026 DUTY_active > PER_active SHALL give 100% duty (PWM_H constantly high in RUN).
REQ-027 PER_active=0 SHALL give a load pulse every cycle in RUN and SHALL NOT lock up.
REQ-028 All comparisons SHALL be unsigned W-bit with no wrap-around arithmetic.
REQ-029 PWM_H and PWM_L SHALL never be 1 in the same cycle.

Reset
REQ-030 On reset=1 at a clk edge, state=IDLE; shadow, active and pending=0; dead-time counter=0.
REQ-031 On reset=1 at a clk edge, load, period_done, PWM_H, PWM_L and COMP0 SHALL all be 0.
REQ-032 reset SHALL dominate enable and wr in the same cycle, including mid-period.

Configuration
REQ-033 With macro PWM_DEADTIME_EN defined, each edge of the raw signal SHALL restart a dead-time counter loaded with DT.
REQ-034 With PWM_DEADTIME_EN defined, the side turning on SHALL assert only after raw has held its level for DT cycles; the side turning off SHALL drop immediately.
REQ-035 With PWM_DEADTIME_EN defined, pulses of DT cycles or fewer SHALL be suppressed on the on-turning side, and DT=0 SHALL equal no dead-time.
REQ-036 Without PWM_DEADTIME_EN, PWM_L SHALL be ~PWM_H in RUN and 0 otherwise, and the DT input SHALL be ignored.

Verification
REQ-037 reset=1 with enable=1 and wr=1 asserted -> all outputs 0 next cycle and state IDLE.
REQ-038 Write PER=9, DUTY=3, then enable -> load pulse in START, then every 10 cycles; PWM_H high for 3 cycles per period.
REQ-039 In RUN, wr with PER=4, DUTY=2 mid-period -> old values used until CNT==0, new values from the next load.
REQ-040 DUTY=0, then DUTY=12 with PER=9 -> PWM_H constantly 0, then constantly 1; PWM_L the complement (no macro).
REQ-041 PWM_DEADTIME_EN, DT=2, PER=9, DUTY=3 -> two both-low cycles at each edge; PWM_H high 1 cycle; no overlap ever.
REQ-042 Deassert enable mid-period at CNT=5 -> outputs 0 next cycle, no further load pulses, active registers track shadow.
